ghost_test_source_ctrl: RTL and testbench

Run controller for the free-running 7-bit test-data counter in the SZ first-stage pipeline. It turns the raw counter into framed, flow-controlled test traffic: a programmable number of frames, each a programmable number of samples, with programmable idle gaps between frames. The output is a valid/ready stream with start-of-frame and end-of-frame markers that feeds the prediction/quantization stages under test.

---
 rtl/ghost_test_source_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ghost_test_source_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_test_source_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ghost_test_source_ctrl
//  Description : Run controller for the free-running test-data counter.
//                Frames the counter into a valid/ready stream with sof/eof
//                markers, a programmable frame count, frame length and
//                inter-frame idle gap, plus stop-at-frame-boundary abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module ghost_test_source_ctrl #(
  parameter int DATA_W = 7,
  parameter int LEN_W  = 10,
  parameter int GAP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [7:0]        cfg_frames,
  input  logic [GAP_W-1:0]  cfg_gap,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Run configuration captured when a start is accepted
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [7:0]         r_frames;
  logic [7:0]         w_frames_nxt;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   w_gap_nxt;

  // Position inside the current frame and remaining idle cycles
  logic [LEN_W-1:0]   r_beat;
  logic [LEN_W-1:0]   w_beat_nxt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [GAP_W-1:0]   w_gap_cnt_nxt;
  logic               r_stop_pend;
  logic               w_stop_pend_nxt;

  // Next values of the registered outputs
  logic [DATA_W-1:0]  w_data_nxt;
  logic               w_valid_nxt;
  logic               w_sof_nxt;
  logic               w_eof_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic [7:0]         w_frame_cnt_nxt;

  logic               w_xfer;
  logic               w_end_run;

  assign w_xfer = valid && ready;

  // Next-state and next-output decode; everything holds unless changed below
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_frames_nxt    = r_frames;
    w_gap_nxt       = r_gap;
    w_beat_nxt      = r_beat;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_stop_pend_nxt = r_stop_pend;
    w_data_nxt      = data_out;
    w_valid_nxt     = valid;
    w_sof_nxt       = sof;
    w_eof_nxt       = eof;
    w_busy_nxt      = busy;
    w_done_nxt      = 1'b0;
    w_frame_cnt_nxt = frame_cnt;
    w_end_run       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A zero-length frame is meaningless, so such a start is dropped
        if (start && (cfg_len != '0)) begin
          w_state_nxt     = ST_RUN;
          w_len_nxt       = cfg_len;
          w_frames_nxt    = cfg_frames;
          w_gap_nxt       = cfg_gap;
          w_beat_nxt      = '0;
          w_stop_pend_nxt = 1'b0;
          w_data_nxt      = '0;
          w_frame_cnt_nxt = '0;
          w_valid_nxt     = 1'b1;
          w_sof_nxt       = 1'b1;
          w_eof_nxt       = (cfg_len == LEN_W'(1));
          w_busy_nxt      = 1'b1;
        end
      end

      ST_RUN: begin
        w_stop_pend_nxt = r_stop_pend | stop;
        if (w_xfer) begin
          w_data_nxt = data_out + DATA_W'(1);
          if (eof) begin
            w_frame_cnt_nxt = frame_cnt + 8'd1;
            // A stop arriving with the eof beat still ends the run here
            if (((r_frames != 8'd0) && (frame_cnt + 8'd1 == r_frames)) ||
                r_stop_pend || stop) begin
              w_end_run = 1'b1;
            end else if (r_gap == '0) begin
              w_beat_nxt = '0;
              w_sof_nxt  = 1'b1;
              w_eof_nxt  = (r_len == LEN_W'(1));
            end else begin
              w_state_nxt   = ST_GAP;
              w_gap_cnt_nxt = r_gap;
              w_valid_nxt   = 1'b0;
              w_sof_nxt     = 1'b0;
              w_eof_nxt     = 1'b0;
            end
          end else begin
            w_beat_nxt = r_beat + LEN_W'(1);
            w_sof_nxt  = 1'b0;
            w_eof_nxt  = (r_beat + LEN_W'(2) == r_len);
          end
        end
      end

      ST_GAP: begin
        // No frame is in flight during the gap, so a stop ends the run at once
        if (stop || r_stop_pend) begin
          w_end_run = 1'b1;
        end else if (r_gap_cnt == GAP_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_beat_nxt  = '0;
          w_valid_nxt = 1'b1;
          w_sof_nxt   = 1'b1;
          w_eof_nxt   = (r_len == LEN_W'(1));
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_end_run) begin
      w_state_nxt     = ST_IDLE;
      w_stop_pend_nxt = 1'b0;
      w_valid_nxt     = 1'b0;
      w_sof_nxt       = 1'b0;
      w_eof_nxt       = 1'b0;
      w_busy_nxt      = 1'b0;
      w_done_nxt      = 1'b1;
    end
  end

  // State register and registered outputs; reset discards any partial frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_frames    <= '0;
      r_gap       <= '0;
      r_beat      <= '0;
      r_gap_cnt   <= '0;
      r_stop_pend <= 1'b0;
      data_out    <= '0;
      valid       <= 1'b0;
      sof         <= 1'b0;
      eof         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_frames    <= w_frames_nxt;
      r_gap       <= w_gap_nxt;
      r_beat      <= w_beat_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      data_out    <= w_data_nxt;
      valid       <= w_valid_nxt;
      sof         <= w_sof_nxt;
      eof         <= w_eof_nxt;
      busy        <= w_busy_nxt;
      done        <= w_done_nxt;
      frame_cnt   <= w_frame_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ghost_test_source_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ghost_test_source_ctrl
//  Description : Randomized and directed stimulus for ghost_test_source_ctrl,
//                compared every cycle against a run-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ghost_test_source_ctrl;

  localparam int DATA_W = 7;
  localparam int LEN_W  = 10;
  localparam int GAP_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              ready = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic [7:0]        cfg_frames = '0;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              sof;
  logic              eof;
  logic              busy;
  logic              done;
  logic [7:0]        frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ghost_test_source_ctrl #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .GAP_W (GAP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cfg_len   (cfg_len),
    .cfg_frames(cfg_frames),
    .cfg_gap   (cfg_gap),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .sof       (sof),
    .eof       (eof),
    .busy      (busy),
    .done      (done),
    .frame_cnt (frame_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Run-level model: n = beats transferred this run, gap = idle cycles left
  typedef struct {
    bit active;
    int gap;
    int n;
    int fdone;
    bit pend;
    bit done;
    int len;
    int frames;
    int gapcfg;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.active = 0; r.gap = 0; r.n = 0; r.fdone = 0; r.pend = 0; r.done = 0;
    r.len = 1; r.frames = 0; r.gapcfg = 0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t s, input logic st,
                                        input logic sp, input logic rd,
                                        input int clen, input int cfr,
                                        input int cgp);
    model_t r;
    bit lof;
    r = s;
    r.done = 0;
    if (!r.active) begin
      if (st && clen != 0) begin
        r.active = 1; r.n = 0; r.fdone = 0; r.pend = 0; r.gap = 0;
        r.len = clen; r.frames = cfr; r.gapcfg = cgp;
      end
    end else if (r.gap > 0) begin
      if (sp || r.pend) begin
        r.active = 0; r.done = 1; r.pend = 0; r.gap = 0;
      end else begin
        r.gap = r.gap - 1;
      end
    end else begin
      r.pend = r.pend || sp;
      if (rd) begin
        lof = (r.n % r.len) == (r.len - 1);
        r.n = r.n + 1;
        if (lof) begin
          r.fdone = r.fdone + 1;
          if ((r.frames != 0 && r.fdone == r.frames) || r.pend) begin
            r.active = 0; r.done = 1; r.pend = 0;
          end else begin
            r.gap = r.gapcfg;
          end
        end
      end
    end
    return r;
  endfunction

  // Advance the model on the same edges the DUT sees
  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, start, stop, ready, int'(cfg_len),
                             int'(cfg_frames), int'(cfg_gap));
  end

  // Compare DUT outputs against the model on every falling edge out of reset
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", int'(busy), int'(m.active));
      check("valid", int'(valid), int'(m.active && m.gap == 0));
      check("done", int'(done), int'(m.done));
      check("frame_cnt", int'(frame_cnt), m.fdone % 256);
      if (m.active && m.gap == 0) begin
        check("data_out", int'(data_out), m.n % 128);
        check("sof", int'(sof), int'((m.n % m.len) == 0));
        check("eof", int'(eof), int'((m.n % m.len) == m.len - 1));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until_done(input int budget, output int nxfer);
    bit got;
    got = 0;
    nxfer = 0;
    for (int c = 0; c < budget && !got; c++) begin
      if (done) got = 1;
      else begin
        if (valid && ready) nxfer = nxfer + 1;
        cyc();
      end
    end
    check("done_within_budget", int'(got), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int beats;
    int idle;
    int nx;
    bit got;
    int rpat[5];

    // Reset state
    repeat (2) cyc();
    check("rst_data", int'(data_out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    rst = 1'b0;
    cyc();

    // Basic run: len 4, frames 2, gap 0
    cfg_len = 10'd4; cfg_frames = 8'd2; cfg_gap = 8'd0; ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    check("lat_busy", int'(busy), 1);
    check("lat_valid", int'(valid), 1);
    for (int i = 0; i < 8; i++) begin
      check("basic_data", int'(data_out), i);
      check("basic_sof", int'(sof), int'(i == 0 || i == 4));
      check("basic_eof", int'(eof), int'(i == 3 || i == 7));
      cyc();
    end
    check("basic_done", int'(done), 1);
    check("basic_busy", int'(busy), 0);
    check("basic_frames", int'(frame_cnt), 2);
    cyc();

    // Gap and wrap: len 130, frames 2, gap 3
    cfg_len = 10'd130; cfg_frames = 8'd2; cfg_gap = 8'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    beats = 0; idle = 0; got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (done) got = 1;
      else begin
        if (valid) begin
          if (beats == 128) check("wrap_data", int'(data_out), 0);
          if (beats == 130) begin
            check("f2_data", int'(data_out), 2);
            check("f2_sof", int'(sof), 1);
          end
          beats = beats + 1;
        end else if (busy) begin
          idle = idle + 1;
        end
        cyc();
      end
    end
    check("gap_done", int'(got), 1);
    check("gap_cycles", idle, 3);
    check("gap_beats", beats, 260);
    check("gap_frames", int'(frame_cnt), 2);
    cyc();

    // Backpressure: len 3, frames 1, ready pattern 1,0,0,1,1
    rpat = '{1, 0, 0, 1, 1};
    cfg_len = 10'd3; cfg_frames = 8'd1; cfg_gap = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    nx = 0;
    for (int i = 0; i < 5; i++) begin
      ready = (rpat[i] != 0);
      if (i == 1 || i == 2) begin
        check("stall_data", int'(data_out), 1);
        check("stall_sof", int'(sof), 0);
        check("stall_eof", int'(eof), 0);
      end
      if (i == 4) check("bp_eof", int'(eof), 1);
      if (valid && ready) begin
        check("bp_xfer_data", int'(data_out), nx);
        nx = nx + 1;
      end
      cyc();
    end
    ready = 1'b1;
    check("bp_xfers", nx, 3);
    check("bp_done", int'(done), 1);
    cyc();

    // Single-beat frames: len 1, frames 3
    cfg_len = 10'd1; cfg_frames = 8'd3; cfg_gap = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("len1_sof", int'(sof), 1);
      check("len1_eof", int'(eof), 1);
      check("len1_data", int'(data_out), i);
      cyc();
    end
    check("len1_done", int'(done), 1);
    check("len1_frames", int'(frame_cnt), 3);
    cyc();

    // Stop during continuous run on the 2nd beat
    cfg_len = 10'd5; cfg_frames = 8'd0; cfg_gap = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    cyc();
    check("stop_last_data", int'(data_out), 4);
    check("stop_last_eof", int'(eof), 1);
    cyc();
    check("stop_done", int'(done), 1);
    check("stop_frames", int'(frame_cnt), 1);
    cyc();

    // Stop during GAP: immediate end
    cfg_len = 10'd2; cfg_frames = 8'd0; cfg_gap = 8'd4; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check("gapstop_valid", int'(valid), 0);
    check("gapstop_busy", int'(busy), 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("gapstop_done", int'(done), 1);
    check("gapstop_busy_after", int'(busy), 0);
    cyc();

    // Illegal start with cfg_len 0
    cfg_len = 10'd0; cfg_frames = 8'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    check("len0_busy", int'(busy), 0);
    cyc();
    check("len0_done", int'(done), 0);

    // Start while busy is ignored
    cfg_len = 10'd4; cfg_frames = 8'd1; cfg_gap = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cfg_len = 10'd1; cfg_frames = 8'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_start_data", int'(data_out), 2);
    check("busy_start_eof", int'(eof), 0);
    cyc();
    check("busy_start_eof3", int'(eof), 1);
    cyc();
    check("busy_start_done", int'(done), 1);
    check("busy_start_frames", int'(frame_cnt), 1);
    cyc();

    // Reset mid-frame, then a fresh start
    cfg_len = 10'd8; cfg_frames = 8'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    check("midrst_data", int'(data_out), 0);
    check("midrst_valid", int'(valid), 0);
    check("midrst_sof", int'(sof), 0);
    check("midrst_eof", int'(eof), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_frames", int'(frame_cnt), 0);
    cyc();
    rst = 1'b0;
    cyc();
    cfg_len = 10'd3; cfg_frames = 8'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    check("fresh_data", int'(data_out), 0);
    check("fresh_sof", int'(sof), 1);
    check("fresh_valid", int'(valid), 1);
    run_until_done(20, nx);
    check("fresh_xfers", nx, 3);
    cyc();

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 1500; c++) begin
      start      = ($urandom % 6 == 0);
      stop       = ($urandom % 20 == 0);
      ready      = ($urandom % 4 != 0);
      cfg_len    = LEN_W'($urandom_range(0, 5));
      cfg_frames = 8'($urandom_range(0, 3));
      cfg_gap    = GAP_W'($urandom_range(0, 3));
      rst        = ($urandom % 200 == 0);
      cyc();
    end
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
